i2c_arbiter: RTL and testbench

Shares the board's single `i2c_master` between two configuration requesters: requester 0 is the SSM2603 bring-up sequencer and requester 1 is the HDMI/aux config sequencer. Grants are round-robin, and each grant covers a whole transaction (start … end). The block forwards one command strobe at a time and holds off new commands until the master reports ready again. It also closes abandoned or stalled transactions itself, so the bus never stays open. It runs on `CLK_I2C`, between the requesters and the `i2c_master` command port.

---
 rtl/i2c_arbiter_if.sv | 36 +++
 rtl/i2c_arbiter.sv | 130 +++++++++++++
 tb/tb_i2c_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_arbiter_if.sv
// Requester-side and i2c_master-side signals of the I2C command arbiter.
// The arbiter uses the slave modport; the driving environment uses master.
interface i2c_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  gnt;
  logic [1:0]  cmd_start;
  logic [1:0]  cmd_end;
  logic [1:0]  cmd_write;
  logic [1:0]  cmd_read;
  logic [15:0] wdata;
  logic [1:0]  ready;
  logic [1:0]  error;
  logic [7:0]  rdata;
  logic        m_start;
  logic        m_end;
  logic        m_write;
  logic        m_read;
  logic [7:0]  m_out;
  logic        m_ready;
  logic        m_error;
  logic [7:0]  m_in;

  modport slave (
    input  req, cmd_start, cmd_end, cmd_write, cmd_read, wdata,
           m_ready, m_error, m_in,
    output gnt, ready, error, rdata,
           m_start, m_end, m_write, m_read, m_out
  );

  modport master (
    output req, cmd_start, cmd_end, cmd_write, cmd_read, wdata,
           m_ready, m_error, m_in,
    input  gnt, ready, error, rdata,
           m_start, m_end, m_write, m_read, m_out
  );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c_master between two config sequencers;
// grants cover whole transactions and abandoned/stalled ones are closed here.
module i2c_arbiter #(
  parameter int unsigned TIMEOUT = 4096,
  parameter int unsigned HOLDOFF = 2
) (
  input  logic        clock,
  input  logic        reset,
  i2c_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, BUSY, CLEANUP} state_t;

  state_t      state;
  logic        last;
  logic        open;
  logic        ended;
  logic [15:0] tcnt;
  logic [15:0] hcnt;
  logic        g;
  logic        win;
  logic [3:0]  strb;
  logic        acc;
  logic        multi;
  logic        tmo;
  logic        rel;
  logic        pulse;
  logic [1:0]  err_n;

  assign g     = bus.gnt[1];
  assign strb  = {bus.cmd_start[g], bus.cmd_end[g], bus.cmd_write[g], bus.cmd_read[g]};
  assign bus.ready = bus.gnt & {2{(state == GRANT) && bus.m_ready}};
  assign bus.rdata = bus.m_in;

  assign acc   = bus.ready[g] && ($countones(strb) == 1);
  assign multi = bus.ready[g] && ($countones(strb) > 1);
  assign tmo   = (tcnt == 16'(TIMEOUT));
  // An accepted command always wins over a release in the same cycle.
  assign rel   = (state == GRANT) && !acc && (!bus.req[g] || tmo);
  assign pulse = (state == GRANT) && !acc && (multi || (bus.req[g] && tmo));

  always_comb begin
    win = (bus.req == 2'b11) ? ~last : bus.req[1];
  end

  always_comb begin
    err_n = '0;
    if (bus.gnt != 2'b00) err_n[g] = bus.m_error | pulse;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      open        <= 1'b0;
      ended       <= 1'b0;
      tcnt        <= '0;
      hcnt        <= '0;
      bus.gnt     <= '0;
      bus.error   <= '0;
      bus.m_start <= 1'b0;
      bus.m_end   <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_read  <= 1'b0;
      bus.m_out   <= '0;
    end else begin
      bus.m_start <= 1'b0;
      bus.m_end   <= 1'b0;
      bus.m_write <= 1'b0;
      bus.m_read  <= 1'b0;
      bus.error   <= err_n;
      case (state)
        IDLE: begin
          if (bus.req != 2'b00) begin
            bus.gnt <= win ? 2'b10 : 2'b01;
            last    <= win;
            tcnt    <= '0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (acc) begin
            bus.m_start <= strb[3];
            bus.m_end   <= strb[2];
            bus.m_write <= strb[1];
            bus.m_read  <= strb[0];
            if (strb[1]) bus.m_out <= g ? bus.wdata[15:8] : bus.wdata[7:0];
            if (strb[3]) open <= 1'b1;
            if (strb[2]) open <= 1'b0;
            hcnt  <= 16'(HOLDOFF);
            state <= BUSY;
          end else if (rel) begin
            if (open) begin
              ended <= 1'b0;
              state <= CLEANUP;
            end else begin
              bus.gnt <= '0;
              state   <= IDLE;
            end
          end else if (!tmo) begin
            tcnt <= tcnt + 16'd1;
          end
        end
        BUSY: begin
          tcnt <= '0;
          if (hcnt != 16'd0) hcnt <= hcnt - 16'd1;
          else if (bus.m_ready) state <= GRANT;
        end
        CLEANUP: begin
          // First phase issues the closing m_end, second waits out its holdoff.
          if (!ended) begin
            if (bus.m_ready) begin
              bus.m_end <= 1'b1;
              open      <= 1'b0;
              ended     <= 1'b1;
              hcnt      <= 16'(HOLDOFF);
            end
          end else if (hcnt != 16'd0) begin
            hcnt <= hcnt - 16'd1;
          end else if (bus.m_ready) begin
            bus.gnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: requester agents push expected master
// strobes, a monitor pops them; a fake i2c_master answers with random latency.
module tb_i2c_arbiter;
  localparam int unsigned TO = 16;
  localparam int unsigned HO = 2;
  localparam int KS = 0, KE = 1, KW = 2, KR = 3, KM = 4;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];
  exp_t e;
  int   mbusy = 0;
  int   post = 0;
  logic [7:0] min_val;
  logic [3:0] mon_s;
  logic mdl_last = 1'b1;

  i2c_arbiter_if bus ();

  i2c_arbiter #(.TIMEOUT(TO), .HOLDOFF(HO)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] kind_of(input logic [3:0] s);
    if (s[3]) return 2'(KS);
    if (s[2]) return 2'(KE);
    if (s[1]) return 2'(KW);
    return 2'(KR);
  endfunction

  // Round-robin rule: a lone requester wins; on a tie the one not served last wins.
  function automatic logic winner(input logic [1:0] r, input logic lst);
    if (r == 2'b11) return (lst == 1'b1) ? 1'b0 : 1'b1;
    return (r == 2'b10);
  endfunction

  // Fake i2c_master: goes busy for a random time after each strobe.
  always @(posedge clock) begin
    #2;
    if (bus.m_start || bus.m_end || bus.m_write || bus.m_read)
      mbusy = $urandom_range(1, 4);
    else if (mbusy > 0)
      mbusy = mbusy - 1;
    bus.m_ready = (mbusy == 0);
    min_val = 8'($urandom);
    bus.m_in = min_val;
    #1;
    check("rdata", 32'(bus.rdata), 32'(min_val));
  end

  always @(negedge clock) begin
    if (!reset) begin
      mon_s = {bus.m_start, bus.m_end, bus.m_write, bus.m_read};
      if (mon_s != 4'b0000) begin
        check("strobe_onehot", 32'($countones(mon_s)), 32'd1);
        check("ready_at_issue", 32'(bus.ready), 32'd0);
        post = HO;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_strobe actual=%b required=none", mon_s);
        end else begin
          e = sbq.pop_front();
          check("strobe_kind", 32'(kind_of(mon_s)), 32'(e.kind));
          if (e.kind == 2'(KW)) check("m_out", 32'(bus.m_out), 32'(e.data));
        end
      end else if (post > 0) begin
        check("ready_holdoff", 32'(bus.ready), 32'd0);
        post = post - 1;
      end
    end
  end

  task automatic clear_cmds();
    bus.cmd_start = '0;
    bus.cmd_end   = '0;
    bus.cmd_write = '0;
    bus.cmd_read  = '0;
  endtask

  task automatic wait_gnt(input logic [1:0] want, input string name);
    int n = 0;
    while (bus.gnt !== want && n < 100) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(bus.gnt), 32'(want));
  endtask

  // Waits for ready, drives one command (plus noise from the other requester),
  // and returns on the negedge of the cycle in which the master strobe shows.
  task automatic issue(input logic g, input int k, input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (bus.ready[g] !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (bus.ready[g] !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL ready_wait actual=%b required=1", bus.ready[g]);
      return;
    end
    clear_cmds();
    bus.wdata = 16'($urandom);
    if (g) bus.wdata[15:8] = d;
    else   bus.wdata[7:0]  = d;
    bus.cmd_start[!g] = 1'($urandom);
    bus.cmd_end[!g]   = 1'($urandom);
    bus.cmd_write[!g] = 1'($urandom);
    bus.cmd_read[!g]  = 1'($urandom);
    case (k)
      KS: bus.cmd_start[g] = 1'b1;
      KE: bus.cmd_end[g]   = 1'b1;
      KW: bus.cmd_write[g] = 1'b1;
      KR: bus.cmd_read[g]  = 1'b1;
      default: begin
        bus.cmd_write[g] = 1'b1;
        bus.cmd_read[g]  = 1'b1;
      end
    endcase
    if (k < KM) sbq.push_back({2'(k), d});
    @(negedge clock);
    clear_cmds();
    if (k == KM) check("multi_error", 32'(bus.error), 32'(2'b01 << g));
  endtask

  task automatic request(input logic [1:0] r);
    logic w;
    bus.req = r;
    w = winner(r, mdl_last);
    wait_gnt(w ? 2'b10 : 2'b01, "gnt_rr");
    mdl_last = w;
  endtask

  task automatic random_round();
    logic [1:0] r;
    logic w;
    logic open;
    int k;
    int nops;
    r = 2'($urandom_range(1, 3));
    w = winner(r, mdl_last);
    request(r);
    open = 1'b0;
    nops = $urandom_range(1, 6);
    for (int i = 0; i < nops; i++) begin
      k = (i == 0) ? KS : $urandom_range(0, 4);
      issue(w, k, 8'($urandom));
      if (k == KS) open = 1'b1;
      if (k == KE) open = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clock);
    end
    if (open) sbq.push_back({2'(KE), 8'h00});
    bus.req = 2'b00;
    wait_gnt(2'b00, "release");
    @(negedge clock);
  endtask

  initial begin
    int n;
    int t;
    bus.req = '0;
    bus.wdata = '0;
    bus.m_error = 1'b0;
    clear_cmds();
    repeat (3) @(negedge clock);
    check("reset_gnt", 32'(bus.gnt), 32'd0);
    check("reset_error", 32'(bus.error), 32'd0);
    check("reset_ready", 32'(bus.ready), 32'd0);
    check("reset_strobes", 32'({bus.m_start, bus.m_end, bus.m_write, bus.m_read}), 32'd0);
    check("reset_m_out", 32'(bus.m_out), 32'd0);

    // Tie from reset goes to requester 0, then hand-over to requester 1.
    reset = 1'b0;
    bus.req = 2'b11;
    @(negedge clock);
    check("first_tie", 32'(bus.gnt), 32'h1);
    bus.req = 2'b10;
    @(negedge clock);
    check("gap_cycle", 32'(bus.gnt), 32'h0);
    @(negedge clock);
    check("regrant", 32'(bus.gnt), 32'h2);
    mdl_last = 1'b1;
    bus.req = 2'b00;
    wait_gnt(2'b00, "release");

    // Complete transaction from requester 0.
    request(2'b01);
    issue(1'b0, KS, 8'h00);
    issue(1'b0, KW, 8'hA5);
    issue(1'b0, KE, 8'h00);
    bus.req = 2'b00;
    wait_gnt(2'b00, "release");

    // Requester 1 abandons an open transaction.
    request(2'b10);
    issue(1'b1, KS, 8'h00);
    sbq.push_back({2'(KE), 8'h00});
    bus.req = 2'b00;
    wait_gnt(2'b00, "abandon_release");

    // Timeout with a transaction open.
    request(2'b01);
    issue(1'b0, KS, 8'h00);
    sbq.push_back({2'(KE), 8'h00});
    n = 0;
    t = 0;
    while (bus.error == 2'b00 && t < 200) begin
      @(negedge clock);
      t++;
      if (bus.ready[0]) n++;
    end
    check("timeout_error", 32'(bus.error), 32'h1);
    check("timeout_window", 32'(n >= int'(TO) && n <= int'(TO) + 1), 32'd1);
    bus.req = 2'b00;
    @(negedge clock);
    check("timeout_pulse_width", 32'(bus.error), 32'h0);
    wait_gnt(2'b00, "timeout_release");

    // Conflicting strobes, then a normal read still goes through.
    request(2'b01);
    issue(1'b0, KM, 8'h00);
    @(negedge clock);
    check("multi_pulse_width", 32'(bus.error), 32'h0);
    issue(1'b0, KR, 8'h00);
    bus.req = 2'b00;
    wait_gnt(2'b00, "release");

    // m_error during BUSY, then reset asserted during BUSY.
    request(2'b10);
    issue(1'b1, KW, 8'h3C);
    bus.m_error = 1'b1;
    @(negedge clock);
    check("m_error_level", 32'(bus.error), 32'h2);
    bus.m_error = 1'b0;
    @(negedge clock);
    check("m_error_clear", 32'(bus.error), 32'h0);
    issue(1'b1, KW, 8'h5A);
    #2;
    reset = 1'b1;
    #1;
    check("busy_reset_gnt", 32'(bus.gnt), 32'd0);
    check("busy_reset_strobes", 32'({bus.m_start, bus.m_end, bus.m_write, bus.m_read}), 32'd0);
    check("busy_reset_ready", 32'(bus.ready), 32'd0);
    check("busy_reset_m_out", 32'(bus.m_out), 32'd0);
    check("busy_reset_error", 32'(bus.error), 32'd0);
    mdl_last = 1'b1;
    bus.req = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 40; i++) random_round();

    repeat (10) @(negedge clock);
    check("scoreboard_drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
